// File: rtl/store_buffer.sv
// FIFO store buffer in front of the data memory: stores retire here, drain one per free cycle, and loads forward youngest-first.
// Optional build macro STORE_BUFFER_COALESCE_EN merges a store into the youngest pending entry with the same address.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [ADDR_W-1:0]      cpu_address,
  input  logic [DATA_W-1:0]      cpu_writeData,
  output logic [DATA_W-1:0]      cpu_readData,
  output logic                   cpu_stall,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [DATA_W-1:0]      mem_writeData,
  input  logic [DATA_W-1:0]      mem_dataOut,
  output logic                   buf_empty,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic             is_load, is_store, load_miss, full;
  logic             enq, drain, coalesce;
  logic             ld_hit;
  logic [PTR_W-1:0] ld_idx, scan_idx;
`ifdef STORE_BUFFER_COALESCE_EN
  logic             st_hit;
  logic [PTR_W-1:0] st_idx;
`endif

  assign is_load  = cpu_read & ~cpu_write;
  assign is_store = cpu_write;
  assign full     = (count_q == CNT_W'(DEPTH));

  // Scan from oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    ld_hit   = 1'b0;
    ld_idx   = '0;
    scan_idx = '0;
`ifdef STORE_BUFFER_COALESCE_EN
    st_hit   = 1'b0;
    st_idx   = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[scan_idx] == cpu_address)) begin
        ld_hit = 1'b1;
        ld_idx = scan_idx;
`ifdef STORE_BUFFER_COALESCE_EN
        // In a store cycle the head always drains when occupied, so it can never be merged into.
        if (k != 0) begin
          st_hit = 1'b1;
          st_idx = scan_idx;
        end
`endif
      end
    end
  end

`ifdef STORE_BUFFER_COALESCE_EN
  assign coalesce = is_store & st_hit & ~reset;
`else
  assign coalesce = 1'b0;
`endif

  assign load_miss = is_load & ~ld_hit;
  assign enq       = is_store & ~coalesce & ~full & ~reset;
  assign drain     = (count_q != '0) & ~load_miss & ~reset;

  always_comb begin
    cpu_stall     = is_store & ~coalesce & full & ~reset;
    MemRead       = load_miss & ~reset;
    MemWrite      = drain;
    mem_address   = '0;
    mem_writeData = '0;
    cpu_readData  = '0;
    if (MemRead) begin
      mem_address = cpu_address;
    end else if (drain) begin
      mem_address   = addr_q[head_q];
      mem_writeData = data_q[head_q];
    end
    if (is_load && !reset) begin
      cpu_readData = ld_hit ? data_q[ld_idx] : mem_dataOut;
    end
    buf_count = reset ? '0 : count_q;
    buf_empty = reset | (count_q == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + PTR_W'(1);
      if (drain) head_q <= head_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(enq) - CNT_W'(drain);
    end
  end

  // Entry storage carries no reset; validity comes from head/count.
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[tail_q] <= cpu_address;
      data_q[tail_q] <= cpu_writeData;
    end
`ifdef STORE_BUFFER_COALESCE_EN
    if (coalesce) data_q[st_idx] <= cpu_writeData;
`endif
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based model of the buffer and a flat memory image.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset, cpu_read, cpu_write;
  logic [7:0] cpu_address, cpu_writeData, cpu_readData;
  logic       cpu_stall, MemRead, MemWrite, buf_empty;
  logic [7:0] mem_address, mem_writeData, mem_dataOut;
  logic [2:0] buf_count;

  always #5 clock = ~clock;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writeData(cpu_writeData), .cpu_readData(cpu_readData),
    .cpu_stall(cpu_stall), .MemRead(MemRead), .MemWrite(MemWrite), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_dataOut(mem_dataOut), .buf_empty(buf_empty),
    .buf_count(buf_count)
  );

  // Memory behind the buffer: combinational read, write on posedge.
  logic [7:0] mem [256] = '{default: 8'h00};
  assign mem_dataOut = mem[mem_address];
  always @(posedge clock) if (MemWrite) mem[mem_address] <= mem_writeData;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } ent_t;
  ent_t       q[$];
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  int n_chk = 0;
  int n_pass = 0;
  logic       obs_stall, obs_mr, obs_mw, obs_empty;
  logic [7:0] obs_rd, obs_ma, obs_wd;
  logic [2:0] obs_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock cycle: drive, check outputs against the model mid-cycle, advance the model.
  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [7:0] a, input logic [7:0] d);
    logic       e_mr, e_mw, e_st, hit, coal, ld;
    logic [7:0] e_rd, e_ma, e_wd;
    int         e_cnt, ci;
    reset = rst; cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_writeData = d;
    @(negedge clock);
    e_mr = 0; e_mw = 0; e_st = 0; hit = 0; coal = 0; ci = 0;
    e_rd = 0; e_ma = 0; e_wd = 0;
    ld = rd && !wr;
    if (!rst) begin
      if (ld) begin
        for (int i = q.size() - 1; i >= 0; i--)
          if (!hit && q[i].a == a) begin hit = 1; e_rd = q[i].d; end
        if (!hit) begin e_mr = 1; e_ma = a; e_rd = ref_mem[a]; end
      end
      if (q.size() > 0 && !e_mr) begin e_mw = 1; e_ma = q[0].a; e_wd = q[0].d; end
`ifdef STORE_BUFFER_COALESCE_EN
      if (wr)
        for (int i = q.size() - 1; i >= 1; i--)
          if (!coal && q[i].a == a) begin coal = 1; ci = i; end
`endif
      if (wr && !coal && q.size() == DEPTH) e_st = 1;
    end
    e_cnt = rst ? 0 : q.size();
    obs_stall = cpu_stall; obs_mr = MemRead; obs_mw = MemWrite; obs_empty = buf_empty;
    obs_rd = cpu_readData; obs_ma = mem_address; obs_wd = mem_writeData; obs_count = buf_count;
    chk("cpu_stall", obs_stall, e_st);
    chk("MemRead", obs_mr, e_mr);
    chk("MemWrite", obs_mw, e_mw);
    chk("cpu_readData", obs_rd, e_rd);
    chk("buf_count", obs_count, e_cnt);
    chk("buf_empty", obs_empty, e_cnt == 0);
    if (e_mr || e_mw) chk("mem_address", obs_ma, e_ma);
    if (e_mw) chk("mem_writeData", obs_wd, e_wd);
    if (rst) q.delete();
    else begin
      if (coal) q[ci].d = d;
      if (e_mw) begin ref_mem[q[0].a] = q[0].d; void'(q.pop_front()); end
      if (wr && !coal && !e_st) q.push_back('{a: a, d: d});
    end
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1; cpu_read = 0; cpu_write = 0; cpu_address = 0; cpu_writeData = 0;
    @(posedge clock); #1;

    step(1, 0, 1, 8'h33, 8'h44);
    step(1, 0, 1, 8'h33, 8'h44);
    chk("rst_count", obs_count, 0);
    chk("rst_memwrite", obs_mw, 0);
    chk("rst_stall", obs_stall, 0);
    chk("rst_empty", obs_empty, 1);

    step(0, 0, 1, 8'h10, 8'h05);
    step(0, 0, 0, 8'h00, 8'h00);
    chk("drain_we", obs_mw, 1);
    chk("drain_addr", obs_ma, 8'h10);
    chk("drain_data", obs_wd, 8'h05);
    step(0, 0, 0, 8'h00, 8'h00);
    chk("drain_empty", obs_empty, 1);

    step(0, 0, 1, 8'h03, 8'hAA);
    step(0, 1, 0, 8'h80, 8'h00);
    chk("miss_holds_count", obs_count, 1);
    step(0, 1, 0, 8'h03, 8'h00);
    chk("fwd_data", obs_rd, 8'hAA);
    chk("fwd_memread", obs_mr, 0);

    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 8'(i), 8'(i + 1));
      step(0, 1, 0, 8'(8'hF0 + i), 8'h00);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 8'h00);

    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 8'(8'h20 + i), 8'(8'hC0 + i));
      chk("wrap_cnt_le4", obs_count <= 4, 1);
      step(0, 0, 0, 8'h00, 8'h00);
    end

    step(0, 0, 1, 8'h07, 8'h11);
    step(0, 1, 0, 8'h90, 8'h00);
    step(0, 0, 1, 8'h07, 8'h22);
    step(0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 8'h00, 8'h00);
    chk("coal_mem07", ref_mem[8'h07] == 8'h22, 1);

    for (int n = 0; n < 600; n++) begin
      int r;
      logic rst, rd, wr;
      r   = $urandom_range(0, 99);
      rst = ($urandom_range(0, 59) == 0);
      rd  = (r < 45) || (r >= 95);
      wr  = (r >= 45 && r < 85) || (r >= 95);
      step(rst, rd, wr, 8'($urandom_range(0, 9)), 8'($urandom));
    end

    for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 0, 0, 8'h00, 8'h00);
    chk("final_empty", q.size(), 0);
    for (int i = 0; i < 256; i++) chk("mem_image", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
